// File: rtl/pipe_pkg.sv
// pipe_pkg: opcodes, instruction classes and default widths shared by the pipelined core
package pipe_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF = 9;
  localparam logic [5:0] OP_ADD = 6'b010000, OP_SUB = 6'b010001, OP_AND = 6'b010010, OP_OR = 6'b010011,
    OP_XOR = 6'b010100, OP_NOR = 6'b010101, OP_XNOR = 6'b010110, OP_NAND = 6'b010111,
    OP_MUL = 6'b011000, OP_DIV = 6'b011001, OP_SLT = 6'b011010, OP_SGT = 6'b011011,
    OP_ADDI = 6'b100010, OP_SUBI = 6'b100011, OP_MULI = 6'b100100, OP_DIVI = 6'b100101,
    OP_SLTI = 6'b100110, OP_SGTI = 6'b100111, OP_LW = 6'b100000, OP_SW = 6'b100001,
    OP_BNEQZ = 6'b101000, OP_BEQZ = 6'b101001, OP_HLT = 6'b111111;
  typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} itype_t;
  function automatic itype_t classify(input logic [5:0] op);
    return (op >= OP_ADD && op <= OP_SGT) ? RR_ALU :
           (op >= OP_ADDI && op <= OP_SGTI) ? RM_ALU :
           op == OP_LW ? LOAD : op == OP_SW ? STORE :
           (op == OP_BNEQZ || op == OP_BEQZ) ? BRANCH : op == OP_HLT ? HALT : NOP;
  endfunction
endpackage

// File: rtl/pipe_regfile.sv
// pipe_regfile: NREGS x XLEN register file, write-through reads, r0 hardwired to zero
module pipe_regfile #(
  parameter int XLEN = 32,
  parameter int NREGS = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic [$clog2(NREGS)-1:0] ra1,
  input  logic [$clog2(NREGS)-1:0] ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic we,
  input  logic [$clog2(NREGS)-1:0] wa,
  input  logic [XLEN-1:0] wd,
  input  logic [$clog2(NREGS)-1:0] dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);
  logic [XLEN-1:0] regs [NREGS];
  assign rd1 = ra1 == '0 ? '0 : (we && wa == ra1) ? wd : regs[ra1];
  assign rd2 = ra2 == '0 ? '0 : (we && wa == ra2) ? wd : regs[ra2];
  assign dbg_rdata = regs[dbg_raddr];
  always_ff @(posedge clk)
    if (rst) regs <= '{default: '0};
    else if (we && wa != '0) regs[wa] <= wd;
endmodule

// File: rtl/pipelined_risc_core.sv
// pipelined_risc_core: five-stage in-order core with forwarding, load-use interlock and halt
module pipelined_risc_core import pipe_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW = AW_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [AW-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic dmem_we,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic [$clog2(NREGS)-1:0] dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata,
  output logic halted,
  output logic retire_valid,
  output logic stall
);
  localparam int RW = $clog2(NREGS);
  logic [AW-1:0] pc, ifid_npc, idex_npc;
  logic [31:0] ifid_ir, idex_ir;
  logic ifid_v, idex_v, exmem_v, memwb_v, exmem_wr, memwb_wr, hlt_seen;
  logic [XLEN-1:0] idex_a, idex_b, exmem_alu, exmem_sd, memwb_val;
  logic [XLEN-1:0] rd1, rd2, fa, fb, alu_b, ex_imm, ex_res;
  logic [RW-1:0] exmem_dst, memwb_dst, id_rs, id_rt, ex_rs, ex_rt, ex_dst;
  itype_t exmem_t, memwb_t, id_t, ex_t;
  logic [5:0] ex_op;
  logic ex_wr, taken, id_hlt, rf_we;
  assign id_t = classify(ifid_ir[31:26]);
  assign id_rs = ifid_ir[21 +: RW];
  assign id_rt = ifid_ir[16 +: RW];
  assign id_hlt = ifid_v && id_t == HALT;
  assign ex_op = idex_ir[31:26];
  assign ex_t = classify(ex_op);
  assign ex_rs = idex_ir[21 +: RW];
  assign ex_rt = idex_ir[16 +: RW];
  assign ex_wr = ex_t inside {RR_ALU, RM_ALU, LOAD};
  assign ex_dst = ex_t == RR_ALU ? idex_ir[11 +: RW] : ex_rt;
  assign ex_imm = XLEN'($signed(idex_ir[15:0]));
  // newest producer wins; r0 is never forwarded
  assign fa = (exmem_v && exmem_wr && exmem_dst != '0 && exmem_dst == ex_rs) ? exmem_alu :
              (memwb_v && memwb_wr && memwb_dst != '0 && memwb_dst == ex_rs) ? memwb_val : idex_a;
  assign fb = (exmem_v && exmem_wr && exmem_dst != '0 && exmem_dst == ex_rt) ? exmem_alu :
              (memwb_v && memwb_wr && memwb_dst != '0 && memwb_dst == ex_rt) ? memwb_val : idex_b;
  assign alu_b = ex_t == RR_ALU ? fb : ex_imm;
  assign taken = idex_v && ex_t == BRANCH && ((fa == '0) == (ex_op == OP_BEQZ));
  assign stall = !halted && ifid_v && idex_v && ex_t == LOAD && ex_dst != '0 &&
                 ((id_t inside {RR_ALU, RM_ALU, LOAD, STORE, BRANCH} && id_rs == ex_dst) ||
                  (id_t inside {RR_ALU, STORE} && id_rt == ex_dst));
  assign rf_we = memwb_v && memwb_wr && !halted;
  assign imem_addr = pc;
  assign dmem_addr = exmem_alu[AW-1:0];
  assign dmem_wdata = exmem_sd;
  assign dmem_we = exmem_v && exmem_t == STORE && !halted;
  assign retire_valid = memwb_v && !halted;
  always_comb begin
    ex_res = fa + alu_b;
    case (ex_op)
      OP_SUB, OP_SUBI: ex_res = fa - alu_b;
      OP_AND: ex_res = fa & alu_b;
      OP_OR: ex_res = fa | alu_b;
      OP_XOR: ex_res = fa ^ alu_b;
      OP_NOR: ex_res = ~(fa | alu_b);
      OP_XNOR: ex_res = ~(fa ^ alu_b);
      OP_NAND: ex_res = ~(fa & alu_b);
      OP_MUL, OP_MULI: ex_res = fa * alu_b;
      OP_DIV, OP_DIVI: ex_res = alu_b == '0 ? '1 : fa / alu_b;
      OP_SLT, OP_SLTI: ex_res = XLEN'(fa < alu_b);
      OP_SGT, OP_SGTI: ex_res = XLEN'(fa > alu_b);
      default: ;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      pc <= '0;
      {ifid_v, idex_v, exmem_v, memwb_v, halted, hlt_seen} <= '0;
    end else if (!halted) begin
      halted <= memwb_v && memwb_t == HALT;
      exmem_v <= idex_v;
      exmem_t <= ex_t;
      exmem_alu <= ex_res;
      exmem_sd <= fb;
      exmem_dst <= ex_dst;
      exmem_wr <= ex_wr;
      memwb_v <= exmem_v;
      memwb_t <= exmem_t;
      memwb_val <= exmem_t == LOAD ? dmem_rdata : exmem_alu;
      memwb_dst <= exmem_dst;
      memwb_wr <= exmem_wr;
      if (taken) begin
        pc <= idex_npc + ex_imm[AW-1:0];
        ifid_v <= 1'b0;
        idex_v <= 1'b0;
      end else if (stall) begin
        idex_v <= 1'b0;
      end else begin
        idex_v <= ifid_v;
        idex_ir <= ifid_ir;
        idex_npc <= ifid_npc;
        idex_a <= rd1;
        idex_b <= rd2;
        hlt_seen <= hlt_seen || id_hlt;
        ifid_v <= !(id_hlt || hlt_seen);
        if (!(id_hlt || hlt_seen)) begin
          pc <= pc + 1'b1;
          ifid_ir <= imem_rdata;
          ifid_npc <= pc + 1'b1;
        end
      end
    end
  pipe_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk(clk), .rst(rst), .ra1(id_rs), .ra2(id_rt), .rd1(rd1), .rd2(rd2),
    .we(rf_we), .wa(memwb_dst), .wd(memwb_val), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );
endmodule

// File: tb/tb_pipelined_risc_core.sv
// tb_pipelined_risc_core: directed programs with hand-computed results for the pipelined core
module tb_pipelined_risc_core;
  import pipe_pkg::*;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [31:0] imem [512], imem16 [512], dmem [512];
  logic [8:0] imem_addr, dmem_addr, imem_addr16, dmem_addr16;
  logic [31:0] dmem_wdata, dbg_rdata;
  logic [15:0] dmem_wdata16, dbg_rdata16;
  logic [4:0] dbg_raddr = 0, dbg_raddr16 = 0;
  logic dmem_we, halted, retire_valid, stall, dmem_we16, halted16, retire16, stall16;
  int total = 0, bad = 0;
  int stalls, rets, wes, k;
  int rc [3];
  logic [8:0] we_a, hold_pc;
  logic [31:0] we_d;

  pipelined_risc_core dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem[imem_addr]),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem[dmem_addr]),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .halted(halted), .retire_valid(retire_valid), .stall(stall)
  );
  pipelined_risc_core #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr16), .imem_rdata(imem16[imem_addr16]),
    .dmem_addr(dmem_addr16), .dmem_wdata(dmem_wdata16), .dmem_we(dmem_we16), .dmem_rdata(16'h0),
    .dbg_raddr(dbg_raddr16), .dbg_rdata(dbg_rdata16), .halted(halted16), .retire_valid(retire16), .stall(stall16)
  );
  always @(posedge clk) if (dmem_we) dmem[dmem_addr] <= dmem_wdata;

  function automatic logic [31:0] rr(input logic [5:0] op, input int d, input int s, input int t);
    return {op, 5'(s), 5'(t), 5'(d), 11'd0};
  endfunction
  function automatic logic [31:0] ri(input logic [5:0] op, input int t, input int s, input int imm);
    return {op, 5'(s), 5'(t), 16'(imm)};
  endfunction
  localparam logic [31:0] HLT = {6'b111111, 26'd0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_reg(input string tag, input int r, input logic [63:0] exp);
    dbg_raddr = 5'(r);
    #1 chk(tag, 64'(dbg_rdata), exp);
  endtask
  task automatic clr();
    for (int i = 0; i < 512; i++) begin imem[i] = '0; dmem[i] = '0; end
  endtask
  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask
  task automatic run(input int max);
    stalls = 0; rets = 0; wes = 0; k = 0;
    while (!halted && k < max) begin
      if (stall) stalls++;
      if (retire_valid) begin
        if (rets < 3) rc[rets] = k;
        rets++;
      end
      if (dmem_we) begin wes++; we_a = dmem_addr; we_d = dmem_wdata; end
      @(negedge clk);
      k++;
    end
    chk("halt_reached", 64'(halted), 1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) imem16[i] = '0;
    imem16[0] = ri(OP_ADDI, 1, 0, 300);
    imem16[1] = ri(OP_ADDI, 2, 0, 300);
    imem16[2] = rr(OP_MUL, 3, 1, 2);
    imem16[3] = rr(OP_DIV, 4, 1, 0);
    imem16[4] = HLT;
    // back-to-back dependent ALU ops
    clr();
    imem[0] = ri(OP_ADDI, 1, 0, 10);
    imem[1] = ri(OP_ADDI, 2, 0, 20);
    imem[2] = rr(OP_ADD, 3, 1, 2);
    imem[3] = HLT;
    do_reset();
    chk("rst_pc", 64'(imem_addr), 0);
    chk("rst_halted", 64'(halted), 0);
    chk("rst_retire", 64'(retire_valid), 0);
    chk("rst_stall", 64'(stall), 0);
    chk("rst_we", 64'(dmem_we), 0);
    run(60);
    chk_reg("fwd_r3", 3, 30);
    chk("fwd_stalls", 64'(stalls), 0);
    chk("fwd_retires", 64'(rets), 4);
    chk("fwd_lat", 64'(rc[0]), 4);
    chk("fwd_ret2", 64'(rc[1]), 5);
    chk("fwd_ret3", 64'(rc[2]), 6);
    // 16-bit instance ran the same time window
    for (int i = 0; i < 60 && !halted16; i++) @(negedge clk);
    chk("x16_halt", 64'(halted16), 1);
    dbg_raddr16 = 3;
    #1 chk("x16_mul", 64'(dbg_rdata16), 64'h5F90);
    dbg_raddr16 = 4;
    #1 chk("x16_div0", 64'(dbg_rdata16), 64'hFFFF);
    // load-use interlock
    @(negedge clk);
    clr();
    dmem[0] = 7;
    imem[0] = ri(OP_LW, 4, 0, 0);
    imem[1] = rr(OP_ADD, 5, 4, 4);
    imem[2] = HLT;
    do_reset();
    run(60);
    chk("lu_stalls", 64'(stalls), 1);
    chk_reg("lu_r4", 4, 7);
    chk_reg("lu_r5", 5, 14);
    chk("lu_retires", 64'(rets), 3);
    // counted loop with taken-branch flushes
    @(negedge clk);
    clr();
    imem[0] = ri(OP_ADDI, 1, 0, 3);
    imem[1] = ri(OP_SUBI, 1, 1, 1);
    imem[2] = ri(OP_BNEQZ, 0, 1, -2);
    imem[3] = ri(OP_ADDI, 6, 6, 1);
    imem[4] = ri(OP_ADDI, 7, 7, 1);
    imem[5] = HLT;
    do_reset();
    run(100);
    chk_reg("loop_r1", 1, 0);
    chk_reg("loop_r6", 6, 1);
    chk_reg("loop_r7", 7, 1);
    chk("loop_retires", 64'(rets), 10);
    // store then halt, then frozen state
    @(negedge clk);
    clr();
    imem[0] = ri(OP_ADDI, 2, 0, 20);
    imem[1] = ri(OP_SW, 2, 0, 5);
    imem[2] = HLT;
    do_reset();
    run(60);
    chk("sw_pulses", 64'(wes), 1);
    chk("sw_addr", 64'(we_a), 5);
    chk("sw_data", 64'(we_d), 20);
    chk("sw_mem", 64'(dmem[5]), 20);
    chk("hlt_pc", 64'(imem_addr), 3);
    hold_pc = imem_addr;
    wes = 0; rets = 0;
    repeat (6) begin
      @(negedge clk);
      if (dmem_we) wes++;
      if (retire_valid) rets++;
    end
    chk("hlt_pc_hold", 64'(imem_addr), 64'(hold_pc));
    chk("hlt_no_we", 64'(wes), 0);
    chk("hlt_no_retire", 64'(rets), 0);
    chk("hlt_still", 64'(halted), 1);
    // reset in the middle of a long loop
    clr();
    imem[0] = ri(OP_ADDI, 1, 0, 100);
    imem[1] = ri(OP_SUBI, 1, 1, 1);
    imem[2] = ri(OP_BNEQZ, 0, 1, -2);
    imem[3] = HLT;
    do_reset();
    repeat (20) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_pc", 64'(imem_addr), 0);
    chk("mid_rst_retire", 64'(retire_valid), 0);
    chk_reg("mid_rst_r1", 1, 0);
    @(negedge clk);
    chk("mid_rst_next", 64'(imem_addr), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
